// File: rtl/hwag_ssram_pkg.sv
// Shared definitions for the hwag ssram register interface.
// Holds the initiator FSM state type, the default bus widths shared with the
// hwag responder top, the default bus-cycle timing, and a small helper used to
// size the phase counter.
package hwag_ssram_pkg;

  localparam int HWAG_ADDR_W    = 8;
  localparam int HWAG_DATA_W    = 16;

  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_STROBE_CYC = 2;
  localparam int DEF_HOLD_CYC   = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } ssram_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/ssram_phase_timer.sv
// Loadable down-counter that times one phase of an ssram bus cycle.
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-low reset
//   load     - load load_val into the counter (wins over counting)
//   load_val - phase length in cycles (>= 1)
//   done     - high during the last cycle of the phase (count == 1)
// The counter parks at zero between phases, so done stays low while idle.
module ssram_phase_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/ssram_initiator.sv
// Bus master for the hwag ssram register interface.
// Takes single read/write requests over a valid/ready handshake, runs a
// setup/strobe/hold bus cycle, and returns a one-cycle response.
// Ports:
//   clk, rst                 - clock (rising edge), async active-low reset
//   req_valid/req_ready      - request handshake
//   req_write/addr/wdata     - request contents (1 = write)
//   rsp_valid                - one-cycle completion pulse (reads and writes)
//   rsp_rdata                - last read value, held until the next read ends
//   ssram_we/re/addr         - bus strobes and address
//   ssram_data               - bidirectional data, driven only for writes
//
// state  | meaning
// IDLE   | ready for a request, bus released
// SETUP  | address (and write data) driven, strobes low
// STROBE | ssram_we or ssram_re high
// HOLD   | strobe low, address/data still held
module ssram_initiator
  import hwag_ssram_pkg::*;
#(
  parameter int ADDR_W     = HWAG_ADDR_W,
  parameter int DATA_W     = HWAG_DATA_W,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ssram_we,
  output logic              ssram_re,
  output logic [ADDR_W-1:0] ssram_addr,
  inout  wire  [DATA_W-1:0] ssram_data
);

  localparam int CNT_W = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);

  ssram_state_e      state, state_nxt;

  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_done;

  logic              data_oe;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;

  logic              ready_nxt;
  logic              rsp_valid_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic              we_nxt;
  logic              re_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              oe_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic              write_nxt;

  ssram_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign ssram_data = data_oe ? wdata_q : {DATA_W{1'bz}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Every bus-facing output is computed one cycle ahead so it leaves a flop.
  always_comb begin
    state_nxt     = state;
    tmr_load      = 1'b0;
    tmr_val       = '0;
    ready_nxt     = req_ready;
    rsp_valid_nxt = 1'b0;
    rdata_nxt     = rsp_rdata;
    we_nxt        = ssram_we;
    re_nxt        = ssram_re;
    addr_nxt      = ssram_addr;
    oe_nxt        = data_oe;
    wdata_nxt     = wdata_q;
    write_nxt     = write_q;

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_nxt = SETUP;
          tmr_load  = 1'b1;
          tmr_val   = CNT_W'(SETUP_CYC);
          ready_nxt = 1'b0;
          write_nxt = req_write;
          addr_nxt  = req_addr;
          wdata_nxt = req_wdata;
          oe_nxt    = req_write;
        end
      end
      SETUP: begin
        if (tmr_done) begin
          state_nxt = STROBE;
          tmr_load  = 1'b1;
          tmr_val   = CNT_W'(STROBE_CYC);
          we_nxt    = write_q;
          re_nxt    = !write_q;
        end
      end
      STROBE: begin
        if (tmr_done) begin
          state_nxt = HOLD;
          tmr_load  = 1'b1;
          tmr_val   = CNT_W'(HOLD_CYC);
          we_nxt    = 1'b0;
          re_nxt    = 1'b0;
          // The responder is still driving the bus during the last strobe cycle.
          if (!write_q) begin
            rdata_nxt = ssram_data;
          end
        end
      end
      HOLD: begin
        if (tmr_done) begin
          state_nxt     = IDLE;
          ready_nxt     = 1'b1;
          rsp_valid_nxt = 1'b1;
          addr_nxt      = '0;
          oe_nxt        = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      ssram_we   <= 1'b0;
      ssram_re   <= 1'b0;
      ssram_addr <= '0;
      data_oe    <= 1'b0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
    end else begin
      req_ready  <= ready_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_rdata  <= rdata_nxt;
      ssram_we   <= we_nxt;
      ssram_re   <= re_nxt;
      ssram_addr <= addr_nxt;
      data_oe    <= oe_nxt;
      wdata_q    <= wdata_nxt;
      write_q    <= write_nxt;
    end
  end

endmodule

// File: tb/tb_ssram_initiator.sv
// Directed bench for ssram_initiator: one instance at default timing with a
// memory responder, one at SETUP=3/STROBE=1/HOLD=2 with a fixed-pattern
// responder ({8'hA5, addr}). Cycle k counts clock edges after acceptance.
`timescale 1ns/1ps
module tb_ssram_initiator;

  int tests_run    = 0;
  int tests_failed = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_req_valid, a_req_ready, a_req_write;
  logic [7:0]  a_req_addr;
  logic [15:0] a_req_wdata;
  logic        a_rsp_valid;
  logic [15:0] a_rsp_rdata;
  logic        a_we, a_re;
  logic [7:0]  a_addr;
  wire  [15:0] a_data;
  logic [15:0] a_mem [256];

  logic        b_req_valid, b_req_ready, b_req_write;
  logic [7:0]  b_req_addr;
  logic [15:0] b_req_wdata;
  logic        b_rsp_valid;
  logic [15:0] b_rsp_rdata;
  logic        b_we, b_re;
  logic [7:0]  b_addr;
  wire  [15:0] b_data;

  logic       prev_rst;
  logic [7:0] prev_a_addr, prev_b_addr;
  logic       prev_a_stb, prev_b_stb;

  ssram_initiator dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
    .ssram_we(a_we), .ssram_re(a_re), .ssram_addr(a_addr), .ssram_data(a_data)
  );

  ssram_initiator #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .ssram_we(b_we), .ssram_re(b_re), .ssram_addr(b_addr), .ssram_data(b_data)
  );

  // Responder models
  assign a_data = a_re ? a_mem[a_addr] : 16'hzzzz;
  always @(posedge clk) if (a_we) a_mem[a_addr] <= a_data;
  assign b_data = b_re ? {8'hA5, b_addr} : 16'hzzzz;

  // Advance one cycle and check bus invariants on both instances.
  task automatic step();
    @(posedge clk); #1;
    if (rst && prev_rst) begin
      tests_run++;
      if ((a_we && a_re) || (b_we && b_re)) begin
        tests_failed++;
        $display("FAIL strobe_excl: a we,re=%b,%b b we,re=%b,%b, required never both high", a_we, a_re, b_we, b_re);
      end
      tests_run++;
      if ((a_addr !== prev_a_addr && (a_we || a_re || prev_a_stb)) ||
          (b_addr !== prev_b_addr && (b_we || b_re || prev_b_stb))) begin
        tests_failed++;
        $display("FAIL addr_stable: a addr %h->%h b addr %h->%h, required no change around strobe", prev_a_addr, a_addr, prev_b_addr, b_addr);
      end
    end
    prev_rst    = rst;
    prev_a_addr = a_addr;
    prev_b_addr = b_addr;
    prev_a_stb  = a_we | a_re;
    prev_b_stb  = b_we | b_re;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0 || a_rsp_rdata !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_rsp: ready=%b rsp_valid=%b rdata=%h, required 1 0 0000", a_req_ready, a_rsp_valid, a_rsp_rdata);
    end
    tests_run++;
    if (a_we !== 1'b0 || a_re !== 1'b0 || a_addr !== 8'h00 || dut_a.data_oe !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_bus: we=%b re=%b addr=%h oe=%b, required 0 0 00 0", a_we, a_re, a_addr, dut_a.data_oe);
    end
    @(negedge clk) rst = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_write();
    step();
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 8'h12; a_req_wdata = 16'h1234;
    step();
    a_req_valid = 1'b0;
    step();
    tests_run++;
    if (a_we !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_strobe: we=%b, required 1 before reset", a_we);
    end
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (a_we !== 1'b0 || a_re !== 1'b0 || dut_a.data_oe !== 1'b0 || a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_async: we=%b re=%b oe=%b ready=%b rsp=%b, required 0 0 0 1 0", a_we, a_re, dut_a.data_oe, a_req_ready, a_rsp_valid);
    end
    step();
    tests_run++;
    if (a_rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_norsp: rsp_valid=%b, required 0", a_rsp_valid);
    end
    @(negedge clk) rst = 1'b1;
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 8'h07; a_req_wdata = 16'h0707;
    step();
    a_req_valid = 1'b0;
    tests_run++;
    if (a_req_ready !== 1'b0 || a_addr !== 8'h07) begin
      tests_failed++;
      $display("FAIL rst_first_accept: ready=%b addr=%h, required 0 07", a_req_ready, a_addr);
    end
    for (int k = 2; k <= 5; k++) begin
      step();
      tests_run++;
      if (a_rsp_valid !== (k == 5)) begin
        tests_failed++;
        $display("FAIL rst_after_rsp k=%0d: rsp_valid=%b, required %b", k, a_rsp_valid, (k == 5));
      end
    end
  endtask

  task automatic test_write();
    logic [5:0] ready_exp = 6'b100000;
    logic [5:0] we_exp    = 6'b001100;
    logic [5:0] oe_exp    = 6'b011110;
    logic [5:0] rsp_exp   = 6'b100000;
    step();
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 8'h05; a_req_wdata = 16'hBEEF;
    for (int k = 1; k <= 5; k++) begin
      step();
      a_req_valid = 1'b0;
      tests_run++;
      if (a_req_ready !== ready_exp[k] || a_we !== we_exp[k] || a_re !== 1'b0 ||
          dut_a.data_oe !== oe_exp[k] || a_rsp_valid !== rsp_exp[k]) begin
        tests_failed++;
        $display("FAIL write_ctl k=%0d: ready=%b we=%b re=%b oe=%b rsp=%b, required %b %b 0 %b %b",
                 k, a_req_ready, a_we, a_re, dut_a.data_oe, a_rsp_valid, ready_exp[k], we_exp[k], oe_exp[k], rsp_exp[k]);
      end
      tests_run++;
      if (a_addr !== ((k <= 4) ? 8'h05 : 8'h00)) begin
        tests_failed++;
        $display("FAIL write_addr k=%0d: addr=%h, required %h", k, a_addr, (k <= 4) ? 8'h05 : 8'h00);
      end
      if (k <= 4) begin
        tests_run++;
        if (a_data !== 16'hBEEF) begin
          tests_failed++;
          $display("FAIL write_data k=%0d: data=%h, required beef", k, a_data);
        end
      end
    end
    tests_run++;
    if (a_rsp_rdata !== 16'h0000) begin
      tests_failed++;
      $display("FAIL write_rdata: rdata=%h, required 0000 (unchanged)", a_rsp_rdata);
    end
  endtask

  task automatic test_read();
    logic [5:0] re_exp  = 6'b001100;
    logic [5:0] rsp_exp = 6'b100000;
    step();
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 8'h05; a_req_wdata = 16'h5555;
    for (int k = 1; k <= 5; k++) begin
      step();
      a_req_valid = 1'b0;
      tests_run++;
      if (a_re !== re_exp[k] || a_we !== 1'b0 || dut_a.data_oe !== 1'b0 || a_rsp_valid !== rsp_exp[k]) begin
        tests_failed++;
        $display("FAIL read_ctl k=%0d: re=%b we=%b oe=%b rsp=%b, required %b 0 0 %b",
                 k, a_re, a_we, dut_a.data_oe, a_rsp_valid, re_exp[k], rsp_exp[k]);
      end
    end
    tests_run++;
    if (a_rsp_rdata !== 16'hBEEF) begin
      tests_failed++;
      $display("FAIL read_rdata: rdata=%h, required beef", a_rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    step();
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 8'h01; a_req_wdata = 16'h003C;
    for (int k = 1; k <= 10; k++) begin
      step();
      tests_run++;
      if (a_rsp_valid !== (k == 5 || k == 10) || a_req_ready !== (k == 5 || k == 10)) begin
        tests_failed++;
        $display("FAIL b2b_hs k=%0d: rsp=%b ready=%b, required %b %b", k, a_rsp_valid, a_req_ready, (k == 5 || k == 10), (k == 5 || k == 10));
      end
      if (k == 5) a_req_write = 1'b0;
      if (k == 6) begin
        a_req_valid = 1'b0;
        tests_run++;
        if (a_addr !== 8'h01 || dut_a.data_oe !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b_second k=6: addr=%h oe=%b, required 01 0", a_addr, dut_a.data_oe);
        end
      end
    end
    tests_run++;
    if (a_rsp_rdata !== 16'h003C) begin
      tests_failed++;
      $display("FAIL b2b_rdata: rdata=%h, required 003c", a_rsp_rdata);
    end
  endtask

  task automatic test_slow_timing();
    logic [7:0] re_exp  = 8'b00010000;
    logic [7:0] rsp_exp = 8'b10000000;
    step();
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 8'hFF; b_req_wdata = 16'h0000;
    for (int k = 1; k <= 7; k++) begin
      step();
      b_req_valid = 1'b0;
      tests_run++;
      if (b_re !== re_exp[k] || b_we !== 1'b0 || dut_b.data_oe !== 1'b0 || b_rsp_valid !== rsp_exp[k] ||
          b_req_ready !== rsp_exp[k] || b_addr !== ((k <= 6) ? 8'hFF : 8'h00)) begin
        tests_failed++;
        $display("FAIL slow_ctl k=%0d: re=%b we=%b oe=%b rsp=%b ready=%b addr=%h, required %b 0 0 %b %b %h",
                 k, b_re, b_we, dut_b.data_oe, b_rsp_valid, b_req_ready, b_addr,
                 re_exp[k], rsp_exp[k], rsp_exp[k], (k <= 6) ? 8'hFF : 8'h00);
      end
    end
    tests_run++;
    if (b_rsp_rdata !== 16'hA5FF) begin
      tests_failed++;
      $display("FAIL slow_rdata: rdata=%h, required a5ff", b_rsp_rdata);
    end
  endtask

  initial begin
    prev_rst = 1'b0; prev_a_addr = 8'h00; prev_b_addr = 8'h00; prev_a_stb = 1'b0; prev_b_stb = 1'b0;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = 8'h00; a_req_wdata = 16'h0000;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 8'h00; b_req_wdata = 16'h0000;
    test_reset();
    test_reset_mid_write();
    test_write();
    test_read();
    test_back_to_back();
    test_slow_timing();
    step();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ssram_initiator.md
Name: ssram_initiator

Overview:
- Bus master for the hwag ssram register interface (8-bit address, 16-bit bidirectional data, separate we/re strobes).
- Accepts single read/write requests from an on-chip client, such as a CPU bridge or a test sequencer, through a valid/ready handshake.
- Generates a timed setup/strobe/hold bus cycle and returns a one-cycle response carrying the read data or the write acknowledge.
- Sits between the client logic and the hwag ssram port. It is the initiator end of the interface that hwag responds to.

Parameters:
- ADDR_W, 8, ssram address width.
- DATA_W, 16, ssram data width.
- SETUP_CYC, 1, cycles the address (and write data) is driven before the strobe; must be >= 1.
- STROBE_CYC, 2, cycles ssram_we or ssram_re is held high; must be >= 1.
- HOLD_CYC, 1, cycles the address/data are held after the strobe drops; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  client request present.
- req_ready  out  1  initiator can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse: transaction complete.
- rsp_rdata  out  DATA_W  read data; holds the last read value.
- ssram_we  out  1  write strobe.
- ssram_re  out  1  read strobe.
- ssram_addr  out  ADDR_W  bus address.
- ssram_data  inout  DATA_W  bus data; driven only during write transactions, high-Z otherwise.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0.
  - ssram_we = 0, ssram_re = 0, ssram_addr = 0, ssram_data released to high-Z.
- Reset mid-transaction: the transaction is dropped with no rsp_valid, and the bus is released immediately.
- All outputs are registered. The data-bus output enable is registered.
- FSM states: IDLE, SETUP, STROBE, HOLD. A phase counter is loaded on every state entry.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready: latch write/addr/wdata, drive ssram_addr, enable the data bus if write, go to SETUP with count SETUP_CYC.
- SETUP: strobes low. After SETUP_CYC cycles, go to STROBE; ssram_we = write or ssram_re = !write.
- STROBE:
  - The strobe stays high for exactly STROBE_CYC cycles.
  - Read data is sampled into rsp_rdata on the clock edge that ends the last STROBE cycle.
  - On that edge the strobe drops and the FSM goes to HOLD.
- HOLD:
  - Address and write data are held for HOLD_CYC cycles.
  - Then the FSM goes to IDLE; the bus is released and rsp_valid = 1 for exactly one cycle.
- rsp_valid pulses for writes too; rsp_rdata is unchanged by writes.
- req_ready = 0 in SETUP/STROBE/HOLD. Requests presented then are ignored (not queued); the client must hold req_valid.
- Throughput: one transaction per 1+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles; 5 at defaults.
  - Back-to-back: a request present in the rsp_valid cycle is accepted in that same cycle.
- Invariants:
  - ssram_we and ssram_re are never high together.
  - The strobe is never high while ssram_addr changes.
  - ssram_data is never driven during read transactions.
- Counter width: $clog2(max(SETUP_CYC,STROBE_CYC,HOLD_CYC)+1). Counter down-counts and the phase advances at count 1.
- rsp_rdata holds its value until the next read completes.

Decomposition:
- Package hwag_ssram_pkg holds:
  - the state enum (IDLE/SETUP/STROBE/HOLD);
  - the default timing constants;
  - ADDR_W/DATA_W defaults shared with the hwag top.
- One sub-module: ssram_phase_timer. It is a loadable down-counter with load value, load strobe and a done flag, and is instantiated once and reloaded per phase.
- The FSM and bus registers live in ssram_initiator.

Test Plan:
- Reset during STROBE of a write to 0x12:
  - Required: we = 0 asynchronously, bus high-Z, no rsp_valid.
  - The next request is accepted on the first cycle after rst goes high.
- Write 0xBEEF to 0x05 (defaults):
  - Required: req_ready drops the cycle after acceptance.
  - ssram_addr = 0x05 for 4 cycles, ssram_we high for exactly cycles 2-3.
  - Data = 0xBEEF driven for cycles 1-4.
  - rsp_valid pulses at cycle 5, rsp_rdata unchanged.
- Read 0x05 with the responder model returning 0xBEEF:
  - Required: re high for 2 cycles, we never high, data never driven.
  - rsp_rdata = 0xBEEF with rsp_valid at cycle 5.
- Back-to-back: write 0x3C→0x01 then read 0x01 with req_valid held high:
  - Required: second acceptance in the rsp_valid cycle of the first.
  - Read returns 0x003C; 10 cycles total.
- SETUP_CYC=3, STROBE_CYC=1, HOLD_CYC=2, read 0xFF:
  - Required: strobe high for exactly 1 cycle, starting 3 cycles after acceptance.
  - rsp_valid at cycle 7; assertion that we & re is never high together holds throughout.
